// File: rtl/data_reader.sv
`default_nettype none
// ============================================================================
// Module   : data_reader
// Purpose  : Memory-to-AXIS streamer. On a start pulse, reads len consecutive
//            words from a 1-cycle-latency BRAM read port starting at
//            base_addr, and emits them in order as an AXIS master stream with
//            tlast on the final beat. A 2-entry output buffer absorbs the
//            read latency and downstream backpressure, so the stream runs at
//            one beat per cycle while m_axis_tready stays high.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1           clock, rising edge
//   rst            in   1           synchronous reset, active-high
//   start          in   1           begin a transfer (ignored while busy)
//   base_addr      in   ADDR_WIDTH  first word address, sampled on start
//   len            in   LEN_WIDTH   transfer length in words, sampled on start
//   busy           out  1           transfer in progress (RUN or DONE)
//   done           out  1           one-cycle completion pulse
//   mem_re         out  1           memory read enable
//   mem_addr       out  ADDR_WIDTH  memory read address
//   mem_do         in   DATA_WIDTH  memory read data, valid 1 cycle after mem_re
//   m_axis_tvalid  out  1           AXIS valid
//   m_axis_tdata   out  DATA_WIDTH  AXIS data
//   m_axis_tlast   out  1           AXIS last beat marker
//   m_axis_tready  in   1           AXIS ready
// ============================================================================
module data_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_do,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;        // base + issued count, wraps naturally
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [LEN_WIDTH-1:0]  sent_q;
    logic                  in_flight_q;   // a read was issued last cycle
    logic                  in_flight_last_q;
    logic [1:0]            occ_q;         // output buffer occupancy, 0..2
    logic [DATA_WIDTH-1:0] head_data_q;
    logic                  head_last_q;
    logic [DATA_WIDTH-1:0] tail_data_q;
    logic                  tail_last_q;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  issue_last;
    logic [2:0]            pending;

    assign pop  = m_axis_tvalid & m_axis_tready;
    assign push = in_flight_q;

    // Words that will occupy the buffer at the next edge if no read is issued
    // now. pop implies occ_q >= 1, so this never underflows.
    assign pending    = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
    assign issue      = (state_q == ST_RUN) && (issued_q < len_q) && (pending < 3'd2);
    assign issue_last = (issued_q == len_q - LEN_WIDTH'(1));

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign mem_re        = issue;
    assign mem_addr      = addr_q;
    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = head_data_q;
    // Head last flag may be stale once the buffer drains, so qualify it.
    assign m_axis_tlast  = m_axis_tvalid & head_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            len_q            <= '0;
            issued_q         <= '0;
            sent_q           <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            occ_q            <= 2'd0;
            head_data_q      <= '0;
            head_last_q      <= 1'b0;
            tail_data_q      <= '0;
            tail_last_q      <= 1'b0;
        end else begin
            // Read pipeline: the last-beat tag travels with the read so it can
            // be stored next to the data when it lands.
            in_flight_q      <= issue;
            in_flight_last_q <= issue & issue_last;

            if (issue) begin
                addr_q   <= addr_q + ADDR_WIDTH'(1);
                issued_q <= issued_q + LEN_WIDTH'(1);
            end

            if (pop) begin
                sent_q <= sent_q + LEN_WIDTH'(1);
            end

            // Two-entry FIFO: head feeds the AXIS port, tail is the spare slot.
            if (push && pop) begin
                if (occ_q == 2'd1) begin
                    head_data_q <= mem_do;
                    head_last_q <= in_flight_last_q;
                end else begin
                    head_data_q <= tail_data_q;
                    head_last_q <= tail_last_q;
                    tail_data_q <= mem_do;
                    tail_last_q <= in_flight_last_q;
                end
            end else if (push) begin
                if (occ_q == 2'd0) begin
                    head_data_q <= mem_do;
                    head_last_q <= in_flight_last_q;
                end else begin
                    tail_data_q <= mem_do;
                    tail_last_q <= in_flight_last_q;
                end
                occ_q <= occ_q + 2'd1;
            end else if (pop) begin
                head_data_q <= tail_data_q;
                head_last_q <= tail_last_q;
                occ_q       <= occ_q - 2'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state_q  <= ST_RUN;
                            len_q    <= len;
                            addr_q   <= base_addr;
                            issued_q <= '0;
                            sent_q   <= '0;
                        end else begin
                            // Empty transfer: report completion without
                            // touching memory or the stream.
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (pop && (sent_q == len_q - LEN_WIDTH'(1))) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
